// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared octet constants and helpers for the Ethernet-style frame path
// Purpose : constants, error codes and LRC/MAC helpers shared by the transmit and receive ends.
// Ports   : none (package).
package eth_pkg;

  localparam logic [7:0] PREAMBLE_OCTET = 8'hAA;
  localparam logic [7:0] SFD_OCTET      = 8'hAB;
  localparam int         MAC_LENGTH     = 6;
  localparam int         PL_LEN_LENGTH  = 2;
  localparam int         FCS_LENGTH     = 4;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNDERRUN = 2'b01,
    ERR_ZERO_LEN = 2'b10
  } err_t;

  // Two's complement of the running LRC, so sum(frame) + fcs == 0 mod 256.
  function automatic logic [7:0] lrc_fcs(input logic [7:0] lrc);
    return (~lrc) + 8'd1;
  endfunction

  // Octet idx of a MAC address, idx 0 being the most significant octet.
  function automatic logic [7:0] mac_octet(input logic [47:0] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    return mac[47:40];
      3'd1:    return mac[39:32];
      3'd2:    return mac[31:24];
      3'd3:    return mac[23:16];
      3'd4:    return mac[15:8];
      default: return mac[7:0];
    endcase
  endfunction

endpackage

// File: rtl/eth_frame_tx_if.sv
// rtl/eth_frame_tx_if.sv - request, payload and line signals of the frame transmitter
// Purpose : bundles the request handshake, payload stream and line outputs.
// Ports   : master = request/payload source and line sink; slave = eth_frame_tx.
interface eth_frame_tx_if;
  logic        req_vld;
  logic        req_rdy;
  logic [47:0] req_dst_mac;
  logic [15:0] req_len;
  logic [7:0]  pl_data;
  logic        pl_vld;
  logic        pl_rdy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        done;
  logic [1:0]  err;

  modport master (
    output req_vld, req_dst_mac, req_len, pl_data, pl_vld,
    input  req_rdy, pl_rdy, tx_data, tx_start, tx_busy, done, err
  );

  modport slave (
    input  req_vld, req_dst_mac, req_len, pl_data, pl_vld,
    output req_rdy, pl_rdy, tx_data, tx_start, tx_busy, done, err
  );
endinterface

// File: rtl/eth_lrc_acc.sv
// rtl/eth_lrc_acc.sv - 8-bit longitudinal redundancy check accumulator
// Purpose : running mod-256 sum of octets and the matching FCS octet.
// Ports   : clk, rst (async active-low), i_clear, i_add_en, i_octet -> o_sum, o_fcs.
module eth_lrc_acc
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_add_en,
  input  logic [7:0] i_octet,
  output logic [7:0] o_sum,
  output logic [7:0] o_fcs
);

  logic [7:0] r_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add_en) begin
      r_sum <= r_sum + i_octet;
    end
  end

  assign o_sum = r_sum;
  assign o_fcs = lrc_fcs(r_sum);

endmodule

// File: rtl/eth_frame_tx.sv
// rtl/eth_frame_tx.sv - serialises one Ethernet-style frame per request onto an octet bus
// Purpose : preamble, SFD, dst MAC, src MAC, length, payload, 4 x LRC FCS, then IFG.
// Ports   : clk, rst (async active-low), bus (eth_frame_tx_if.slave: request, payload, line).
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter logic [47:0] SRC_MAC_ADDR = 48'h00_0a_95_9d_68_17,
  parameter int          PREAMBLE_LEN = 7,
  parameter int          IFG_CYCLES   = 4
) (
  input  logic         clk,
  input  logic         rst,
  eth_frame_tx_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_MACDST, S_MACSRC, S_LEN, S_PL, S_FCS, S_IFG
  } state_t;

  state_t      r_state, w_next_state;
  logic [15:0] r_cnt, w_next_cnt, w_state_len;
  logic [47:0] r_dst;
  logic [15:0] r_len;
  logic        r_underrun, r_req_rdy;
  logic [7:0]  r_tx_data, w_nxt_octet;
  logic        r_tx_start, r_tx_busy, r_done;
  err_t        r_err;
  logic        w_req_fire, w_zero_req, w_last, w_frame_end, w_lrc_add;
  logic [7:0]  w_lrc_sum, w_lrc_fcs;

  assign w_req_fire  = r_req_rdy && bus.req_vld;
  assign w_zero_req  = w_req_fire && (bus.req_len == 16'd0);
  assign w_frame_end = (r_state == S_FCS) && (w_next_state == S_IFG);

  always_comb begin
    w_state_len = 16'd1;
    case (r_state)
      S_PREAMBLE: w_state_len = 16'(PREAMBLE_LEN);
      S_MACDST:   w_state_len = 16'(MAC_LENGTH);
      S_MACSRC:   w_state_len = 16'(MAC_LENGTH);
      S_LEN:      w_state_len = 16'(PL_LEN_LENGTH);
      S_PL:       w_state_len = r_len;
      S_FCS:      w_state_len = 16'(FCS_LENGTH);
      S_IFG:      w_state_len = 16'(IFG_CYCLES);
      default:    w_state_len = 16'd1;
    endcase
  end

  assign w_last = (r_cnt == w_state_len - 16'd1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_req_fire && !w_zero_req) w_next_state = S_PREAMBLE;
      S_PREAMBLE: if (w_last) w_next_state = S_SFD;
      S_SFD:      if (w_last) w_next_state = S_MACDST;
      S_MACDST:   if (w_last) w_next_state = S_MACSRC;
      S_MACSRC:   if (w_last) w_next_state = S_LEN;
      S_LEN:      if (w_last) w_next_state = S_PL;
      S_PL:       if (w_last) w_next_state = S_FCS;
      S_FCS:      if (w_last) w_next_state = S_IFG;
      S_IFG:      if (w_last) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
    w_next_cnt = ((w_next_state != r_state) || (w_next_state == S_IDLE)) ? 16'd0 : r_cnt + 16'd1;
  end

  // Output logic: the octet for the next line cycle is chosen here and registered,
  // so pl_rdy is simply "next line octet is payload".
  always_comb begin
    bus.pl_rdy  = (w_next_state == S_PL);
    w_lrc_add   = 1'b0;
    w_nxt_octet = 8'h00;
    case (w_next_state)
      S_PREAMBLE: w_nxt_octet = PREAMBLE_OCTET;
      S_SFD:      w_nxt_octet = SFD_OCTET;
      S_MACDST: begin
        w_nxt_octet = mac_octet(r_dst, w_next_cnt[2:0]);
        w_lrc_add   = 1'b1;
      end
      S_MACSRC: begin
        w_nxt_octet = mac_octet(SRC_MAC_ADDR, w_next_cnt[2:0]);
        w_lrc_add   = 1'b1;
      end
      S_LEN: begin
        w_nxt_octet = (w_next_cnt == 16'd0) ? r_len[15:8] : r_len[7:0];
        w_lrc_add   = 1'b1;
      end
      S_PL: begin
        w_nxt_octet = bus.pl_vld ? bus.pl_data : 8'h00;
        w_lrc_add   = 1'b1;
      end
      // ~((~sum)+1) == sum-1: the poisoned FCS after an underrun.
      S_FCS:      w_nxt_octet = r_underrun ? (w_lrc_sum - 8'd1) : w_lrc_fcs;
      default:    w_nxt_octet = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_tx_busy  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= ERR_NONE;
      r_req_rdy  <= 1'b0;
      r_dst      <= '0;
      r_len      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_tx_data  <= w_nxt_octet;
      r_tx_start <= w_req_fire && !w_zero_req;
      r_tx_busy  <= (w_next_state != S_IDLE);
      r_req_rdy  <= (w_next_state == S_IDLE);
      r_done     <= w_zero_req || w_frame_end;
      r_err      <= w_zero_req ? ERR_ZERO_LEN :
                    (w_frame_end && r_underrun) ? ERR_UNDERRUN : ERR_NONE;
      if (w_req_fire && !w_zero_req) begin
        r_dst      <= bus.req_dst_mac;
        r_len      <= bus.req_len;
        r_underrun <= 1'b0;
      end else if (bus.pl_rdy && !bus.pl_vld) begin
        r_underrun <= 1'b1;
      end
    end
  end

  eth_lrc_acc u_lrc (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state == S_IDLE),
    .i_add_en (w_lrc_add),
    .i_octet  (w_nxt_octet),
    .o_sum    (w_lrc_sum),
    .o_fcs    (w_lrc_fcs)
  );

  assign bus.req_rdy  = r_req_rdy;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_busy  = r_tx_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule
